tx_frame_sched: RTL and testbench
=================================

# tx_frame_sched

Frame scheduler and round-robin arbiter for the shared UART transmit path. Up to R requesters each offer a K-bit word through a valid/ready handshake. The scheduler grants one word at a time and presents it on `tx_word` to the Encryption → encoding → PISO `tx` chain. It pulses `tx_load` and blocks further grants until the full N+2-bit frame (start bit, N code bits, stop bit) plus a programmable idle gap has left the line.

## Interface
- `K`, 4: data word width; equals the encryption/encoding input width.
- `N`, 7: encoded codeword width; frame length on the line is N+2 bits.
- `R`, 4: number of requesters; must be ≥ 2.
- `GAP`, 0: extra idle cycles inserted after each frame; 0 is legal.
- `clk`  in  1  single system clock; `tx` shifts one bit per cycle of this clock.
- `rst_n`  in  1  asynchronous, active-low reset; shared with `tx`.
- `req_valid`  in  R  per-requester word-available flags.
- `req_data`  in  R*K  packed words; requester i occupies bits [i*K+K-1 : i*K].
- `req_ready`  out  R  one-hot accept strobe; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `tx_word`  out  K  registered word for the encryption/encoding chain.
- `tx_load`  out  1  one-cycle load strobe to `tx`.
- `grant_id`  out  clog2(R)  index of the requester whose word is in flight.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse on the last bit cycle of a frame.
- `frame_cnt`  out  16  count of completed frames; wraps.

## Operation
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE
  - If any `req_valid` is high, the round-robin winner gets `req_ready` high combinationally in the same cycle.
  - At that clock edge: `tx_word` ← winner's data, `grant_id` ← winner, state → LOAD.
  - If no requester is valid, the state stays IDLE and `req_ready` stays 0.
- LOAD
  - `tx_load` = 1 for exactly one cycle; `tx` captures {1, codeword, 0} at this edge.
  - State → SHIFT; the bit counter clears to 0.
- SHIFT
  - Counts FRAME_LEN = N+2 cycles.
  - `frame_done` = 1 when the counter equals N+1; `frame_cnt` increments at that edge.
  - At the end of SHIFT, state → GAP if GAP > 0, otherwise → IDLE.
- GAP
  - Counts GAP cycles, then state → IDLE.
- Round-robin arbitration
  - The search starts at `grant_id`+1 modulo R.
  - The pointer updates only on an accepted transfer.
  - After reset the pointer is R-1, so requester 0 has first priority.
- `tx_word` and `grant_id` hold their values from acceptance until the next acceptance.
- `req_ready` is 0 in every state except IDLE. A requester that drops `req_valid` while not granted loses nothing.
- `req_valid` changing during LOAD, SHIFT or GAP has no effect on the current frame.

## Timing
- Reset values: state IDLE, `req_ready` 0, `tx_word` 0, `tx_load` 0, `grant_id` R-1, `busy` 0, `frame_done` 0, `frame_cnt` 0, all counters 0.
- Reset asserted mid-frame aborts immediately: the FSM returns to IDLE and no `frame_done` is produced. `tx` is cleared by the same `rst_n`.
- Acceptance cycle t:
  - `tx_load` high in cycle t+1.
  - `tx` `data_out` carries frame bits 0..N+1 in cycles t+2 .. t+N+3.
  - `frame_done` high in cycle t+N+3.
  - Next acceptance possible at cycle t+N+4+GAP.
- Back-to-back throughput is one word per N+4+GAP cycles; with the defaults that is 11 cycles.
- `tx_word` is stable from t+1 onward, so the combinational encrypt/encode path settles before the `tx_load` edge.
- `frame_cnt` wraps from 16'hFFFF to 0 without a flag.

## Structure
- Package `tx_sched_pkg` contains:
  - the state enum (IDLE, LOAD, SHIFT, GAP);
  - the `FRAME_LEN` = N+2 helper;
  - the counter width = clog2(max(FRAME_LEN, GAP+1)).
- Sub-module `rr_arbiter`, parameterised by R:
  - inputs: the request vector, the last-grant pointer and an enable;
  - outputs: a one-hot grant vector and a binary grant index.
- `tx_frame_sched` instantiates `rr_arbiter`, the FSM and the counters.

## Test plan
- Reset release, then req_valid=4'b0001 with data 4'hA at cycle 0 → `req_ready`=0001 at cycle 0, `tx_load` at cycle 1, `tx_word`=4'hA, `frame_done` at cycle 10, `frame_cnt`=1.
- All four requesters valid continuously with GAP=0 → grants in order 0,1,2,3,0, with acceptances exactly 11 cycles apart.
- GAP=3 with a single requester always valid → acceptances 14 cycles apart; `busy` stays high through the GAP cycles.
- `rst_n` pulsed low during SHIFT (bit counter = 4) → all outputs return to their reset values immediately; no `frame_done`; next grant goes to requester 0.
- A requester raises `req_valid` during SHIFT → `req_ready` stays 0 until IDLE, then the word is accepted; no lost or duplicated transfer.
- Force `frame_cnt` to 16'hFFFF and complete one frame → `frame_cnt`=0.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared types and sizing helpers for the UART transmit frame scheduler.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

    // Bits on the line per frame: start bit, N code bits, stop bit.
    function automatic int frame_len(input int n);
        return n + 2;
    endfunction

    // One counter serves both the SHIFT and GAP phases, so it must hold the larger span.
    function automatic int cnt_width(input int n, input int gap);
        int span;
        int w;
        span = (frame_len(n) > gap + 1) ? frame_len(n) : gap + 1;
        w    = $clog2(span);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tx_frame_sched_rr_arbiter.sv
// Round-robin arbiter: searches from last+1 (mod R) and returns the first active request.
module rr_arbiter #(
    parameter int R  = 4,
    parameter int IW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          en,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Rotating priority search; the index holds the previous winner when nothing is granted.
    always_comb begin
        int  cand;
        logic found;
        grant = '0;
        idx   = last;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= R; k++) begin
            cand = (int'(last) + k) % R;
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/tx_frame_sched.sv
// Frame scheduler for the shared UART transmit path: arbitrates requesters,
// loads one word into the tx chain and holds off until frame plus idle gap is out.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | no frame in flight; round-robin winner is accepted this cycle
//  ST_LOAD  | tx_load strobe; tx captures {stop, codeword, start}
//  ST_SHIFT | frame bits on the line, bit_cnt 0..FRAME_LEN-1
//  ST_GAP   | programmable idle gap, bit_cnt 0..GAP-1
module tx_frame_sched
    import tx_sched_pkg::*;
#(
    parameter  int K   = 4,
    parameter  int N   = 7,
    parameter  int R   = 4,
    parameter  int GAP = 0,
    localparam int IW  = $clog2(R)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    req_valid,
    input  logic [R*K-1:0]  req_data,
    output logic [R-1:0]    req_ready,
    output logic [K-1:0]    tx_word,
    output logic            tx_load,
    output logic [IW-1:0]   grant_id,
    output logic            busy,
    output logic            frame_done,
    output logic [15:0]     frame_cnt
);

    localparam int FL = frame_len(N);
    localparam int CW = cnt_width(N, GAP);

    sched_state_t   state;
    sched_state_t   state_nxt;
    logic [CW-1:0]  bit_cnt;
    logic [R-1:0]   grant;
    logic [IW-1:0]  win_idx;
    logic           accept;
    logic           shift_last;
    logic           gap_last;

    // Arbitration only runs while idle, so req_ready is zero in every other state.
    rr_arbiter #(
        .R  (R),
        .IW (IW)
    ) u_arb (
        .req   (req_valid),
        .last  (grant_id),
        .en    (state == ST_IDLE),
        .grant (grant),
        .idx   (win_idx)
    );

    assign req_ready  = grant;
    assign accept     = |grant;
    assign shift_last = (state == ST_SHIFT) && (bit_cnt == CW'(FL - 1));
    assign gap_last   = (state == ST_GAP) && (bit_cnt == CW'(GAP - 1));

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_nxt  = state;
        tx_load    = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_load   = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shift_last) begin
                    frame_done = 1'b1;
                    state_nxt  = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shared bit/gap counter; restarts at zero on entry to SHIFT and to GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_SHIFT: bit_cnt <= shift_last ? '0 : bit_cnt + 1'b1;
                ST_GAP:   bit_cnt <= gap_last ? '0 : bit_cnt + 1'b1;
                default:  bit_cnt <= '0;
            endcase
        end
    end

    // Capture the accepted word and its owner; held until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_word  <= '0;
            grant_id <= IW'(R - 1);
        end else if (accept) begin
            tx_word  <= req_data[win_idx*K +: K];
            grant_id <= win_idx;
        end
    end

    // Completed-frame counter, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Bench for tx_frame_sched: cycle-level reference model with a word scoreboard,
// plus a second instance with a non-zero idle gap.
module tb_tx_frame_sched;

    localparam int K = 4;
    localparam int N = 7;
    localparam int R = 4;
    localparam int GAP_G = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [R-1:0]   req_valid;
    logic [R*K-1:0] req_data;
    logic [R-1:0]   req_ready;
    logic [K-1:0]   tx_word;
    logic           tx_load;
    logic [1:0]     grant_id;
    logic           busy;
    logic           frame_done;
    logic [15:0]    frame_cnt;

    logic [R-1:0]   g_valid;
    logic [R*K-1:0] g_data;
    logic [R-1:0]   g_ready;
    logic [K-1:0]   g_word;
    logic           g_load;
    logic [1:0]     g_gid;
    logic           g_busy;
    logic           g_done;
    logic [15:0]    g_fcnt;

    tx_frame_sched #(.K(K), .N(N), .R(R), .GAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_word(tx_word), .tx_load(tx_load),
        .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    tx_frame_sched #(.K(K), .N(N), .R(R), .GAP(GAP_G)) dut_g (
        .clk(clk), .rst_n(rst_n), .req_valid(g_valid), .req_data(g_data),
        .req_ready(g_ready), .tx_word(g_word), .tx_load(g_load),
        .grant_id(g_gid), .busy(g_busy), .frame_done(g_done), .frame_cnt(g_fcnt)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int             id;
        logic [K-1:0]   w;
    } sb_t;

    typedef struct {
        int id;
        int at;
    } acc_t;

    sb_t  sb[$];
    acc_t acc_log[$];

    int          m_ptr = R - 1;
    int          m_acc = -1000;
    logic [15:0] m_fcnt = 16'd0;
    logic        force_req = 1'b0;

    function automatic int rr_pick(input logic [R-1:0] v, input int ptr);
        for (int k = 1; k <= R; k++) begin
            if (v[(ptr + k) % R]) return (ptr + k) % R;
        end
        return -1;
    endfunction

    // Reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_word", tx_word, 0);
            chk("rst_load", tx_load, 0);
            chk("rst_gid", grant_id, R - 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", frame_done, 0);
            chk("rst_fcnt", frame_cnt, 0);
            m_ptr  = R - 1;
            m_acc  = -1000;
            m_fcnt = 16'd0;
            sb.delete();
            acc_log.delete();
        end else begin
            int          win;
            logic        ready_ok;
            logic        exp_done;
            logic [R-1:0] exp_ready;
            sb_t         e;
            if (force_req) m_fcnt = 16'hFFFF;
            ready_ok  = (cyc >= m_acc + N + 4);
            win       = rr_pick(req_valid, m_ptr);
            exp_ready = (ready_ok && win >= 0) ? (R'(1) << win) : '0;
            exp_done  = (cyc == m_acc + N + 3);
            chk("req_ready", req_ready, exp_ready);
            chk("tx_load", tx_load, cyc == m_acc + 1);
            chk("frame_done", frame_done, exp_done);
            chk("busy", busy, !ready_ok);
            chk("frame_cnt", frame_cnt, m_fcnt);
            if (tx_load) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("tx_word", tx_word, e.w);
                    chk("grant_id", grant_id, e.id);
                end
            end
            if (exp_done) m_fcnt = m_fcnt + 16'd1;
            if (exp_ready != '0) begin
                e.id = win;
                e.w  = req_data[win*K +: K];
                sb.push_back(e);
                acc_log.push_back('{id: win, at: cyc});
                m_ptr = win;
                m_acc = cyc;
            end
        end
    end

    task automatic raise(input int i, input logic [K-1:0] d);
        req_data[i*K +: K] = d;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        bit got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) got = 1;
        end
        chk("accept_seen", got, 1);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic send(input int i, input logic [K-1:0] d);
        @(posedge clk);
        #1 raise(i, d);
        wait_accept(i);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int c = 0; c < 60 && !idle; c++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        chk("idle_seen", idle, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int last;
        int n_acc;
        req_valid = '0;
        req_data  = '0;
        g_valid   = '0;
        g_data    = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // single word from requester 0
        send(0, 4'hA);
        wait_idle();
        chk("t1_fcnt", frame_cnt, 1);

        // all requesters valid back-to-back from a fresh reset
        do_reset();
        @(posedge clk);
        #1 req_data = {4'h4, 4'h3, 4'h2, 4'h1};
        req_valid = '1;
        repeat (55) @(posedge clk);
        #1 req_valid = '0;
        wait_idle();
        chk("rr_count", acc_log.size(), 5);
        if (acc_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", acc_log[k].id, k % R);
            for (int k = 1; k < 5; k++) chk("rr_spacing", acc_log[k].at - acc_log[k-1].at, N + 4);
        end

        // reset in the middle of SHIFT
        send(2, 4'h5);
        repeat (5) @(posedge clk);
        #2 chk("pre_rst_cnt", dut.bit_cnt, 4);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", frame_done, 0);
        chk("abort_word", tx_word, 0);
        chk("abort_gid", grant_id, R - 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_data  = {4'h0, 4'h0, 4'hE, 4'hD};
        req_valid = 4'b0011;
        repeat (15) @(posedge clk);
        #1 req_valid = '0;
        wait_idle();
        chk("post_rst_n", acc_log.size(), 2);
        if (acc_log.size() >= 2) begin
            chk("post_rst_first", acc_log[0].id, 0);
            chk("post_rst_second", acc_log[1].id, 1);
        end

        // requester appears while a frame is shifting
        base = acc_log.size();
        send(1, 4'h9);
        repeat (3) @(posedge clk);
        #1 raise(3, 4'hC);
        wait_accept(3);
        wait_idle();
        chk("late_req_accepts", acc_log.size() - base, 2);
        chk("late_req_sb_empty", sb.size(), 0);

        // frame counter wrap
        @(posedge clk);
        #1 force dut.frame_cnt = 16'hFFFF;
        #1 release dut.frame_cnt;
        force_req = 1'b1;
        @(posedge clk);
        #1 force_req = 1'b0;
        send(2, 4'h6);
        wait_idle();
        chk("fcnt_wrap", frame_cnt, 0);

        // idle gap instance, single requester always valid
        @(posedge clk);
        #1 g_data = {12'h000, 4'h7};
        g_valid = 4'b0001;
        last  = -1;
        n_acc = 0;
        for (int c = 0; c < 100 && n_acc < 4; c++) begin
            @(negedge clk);
            if (g_load) begin
                chk("gap_word", g_word, 4'h7);
                chk("gap_gid", g_gid, 0);
            end
            if (g_ready[0]) begin
                if (last >= 0) chk("gap_spacing", cyc - last, N + 4 + GAP_G);
                last = cyc;
                n_acc++;
            end else if (last >= 0) begin
                chk("gap_busy", g_busy, 1);
            end
        end
        chk("gap_accepts", n_acc, 4);
        @(posedge clk);
        #1 g_valid = '0;

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
